// File: rtl/serial_feeder.sv
// serial_feeder: parallel-to-serial feeder for the sequence detector's single-bit input.
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   data_in       in   NUM_BITS-wide parallel word
//   data_valid    in   producer has a word on data_in
//   data_ready    out  feeder can take a word (holding register empty)
//   shift_en      in   pacing strobe, consumes one bit of the active word
//   serial_out    out  current serial bit (0 while idle)
//   serial_active out  a word is being shifted
//   word_done     out  one-cycle pulse after a word's last bit is consumed
module serial_feeder #(
    parameter int NUM_BITS  = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic                shift_en,
    output logic                serial_out,
    output logic                serial_active,
    output logic                word_done
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam int CW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    logic [0:0]          r_state;
    logic [NUM_BITS-1:0] r_sr;
    logic [NUM_BITS-1:0] r_hr;
    logic [CW-1:0]       r_cnt;
    logic                r_hold_full;
    logic                r_word_done;
    logic                w_accept;
    logic                w_last;
    logic [NUM_BITS-1:0] w_shifted;

    assign w_accept  = data_valid && !r_hold_full;
    // Last bit of the active word is being consumed on this edge.
    assign w_last    = (r_state == S_SHIFT) && shift_en && (r_cnt == LAST);
    assign w_shifted = MSB_FIRST ? {r_sr[NUM_BITS-2:0], 1'b0} : {1'b0, r_sr[NUM_BITS-1:1]};

    assign data_ready    = !r_hold_full;
    assign serial_active = (r_state == S_SHIFT);
    assign serial_out    = (r_state == S_SHIFT) && (MSB_FIRST ? r_sr[NUM_BITS-1] : r_sr[0]);
    assign word_done     = r_word_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_hr        <= '0;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= w_last;
            if (r_state == S_IDLE) begin
                // Load straight into SR so the holding register is never full while idle.
                if (w_accept) begin
                    r_sr    <= data_in;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
            end else if (w_last) begin
                // Hand off with no gap: reserved word first, else a word arriving this edge.
                r_cnt <= '0;
                if (r_hold_full) begin
                    r_sr        <= r_hr;
                    r_hold_full <= 1'b0;
                end else if (w_accept) begin
                    r_sr <= data_in;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                if (shift_en) begin
                    r_sr  <= w_shifted;
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_hr        <= data_in;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: directed self-checking bench for serial_feeder (8-bit MSB-first and 4-bit LSB-first).
module tb_serial_feeder;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] din_a = '0;
    logic       valid_a = 1'b0;
    logic       sh_a = 1'b0;
    logic       ready_a, out_a, active_a, done_a;
    logic [3:0] din_b = '0;
    logic       valid_b = 1'b0;
    logic       sh_b = 1'b0;
    logic       ready_b, out_b, active_b, done_b;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    serial_feeder #(.NUM_BITS(8), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .data_in(din_a), .data_valid(valid_a), .data_ready(ready_a),
        .shift_en(sh_a), .serial_out(out_a), .serial_active(active_a), .word_done(done_a)
    );

    serial_feeder #(.NUM_BITS(4), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .data_in(din_b), .data_valid(valid_b), .data_ready(ready_b),
        .shift_en(sh_b), .serial_out(out_b), .serial_active(active_b), .word_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_out"}, {31'd0, out_a}, 32'd0);
        check({tag, "_active"}, {31'd0, active_a}, 32'd0);
        check({tag, "_ready"}, {31'd0, ready_a}, 32'd1);
        check({tag, "_done"}, {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;
        logic [3:0]  w4;
        #12;
        check_idle_a("rst");
        check("rst_b_out", {31'd0, out_b}, 32'd0);
        check("rst_b_ready", {31'd0, ready_b}, 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        cyc();
        check_idle_a("idle");

        // single word 1101_0000, continuous shift_en
        w8 = 8'b1101_0000;
        din_a = w8; valid_a = 1'b1; sh_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("single_bit%0d", i), {31'd0, out_a}, {31'd0, w8[7-i]});
            check($sformatf("single_act%0d", i), {31'd0, active_a}, 32'd1);
            check($sformatf("single_done%0d", i), {31'd0, done_a}, 32'd0);
            cyc();
        end
        check("single_done_pulse", {31'd0, done_a}, 32'd1);
        check("single_idle_out", {31'd0, out_a}, 32'd0);
        check("single_idle_act", {31'd0, active_a}, 32'd0);
        cyc();
        check("single_done_end", {31'd0, done_a}, 32'd0);

        // back-to-back B4 then 0D
        w16 = 16'hB40D;
        din_a = 8'hB4; valid_a = 1'b1;
        cyc();
        check("b2b_bit0", {31'd0, out_a}, {31'd0, w16[15]});
        check("b2b_ready0", {31'd0, ready_a}, 32'd1);
        din_a = 8'h0D;
        cyc();
        valid_a = 1'b0;
        din_a = 8'h55;
        check("b2b_bit1", {31'd0, out_a}, {31'd0, w16[14]});
        check("b2b_ready1", {31'd0, ready_a}, 32'd0);
        for (int k = 2; k < 16; k++) begin
            cyc();
            check($sformatf("b2b_bit%0d", k), {31'd0, out_a}, {31'd0, w16[15-k]});
            check($sformatf("b2b_act%0d", k), {31'd0, active_a}, 32'd1);
            check($sformatf("b2b_ready%0d", k), {31'd0, ready_a}, (k >= 8) ? 32'd1 : 32'd0);
            check($sformatf("b2b_done%0d", k), {31'd0, done_a}, (k == 8) ? 32'd1 : 32'd0);
        end
        cyc();
        check("b2b_done_last", {31'd0, done_a}, 32'd1);
        check("b2b_idle_act", {31'd0, active_a}, 32'd0);

        // stalled pacing on A5
        w8 = 8'hA5;
        din_a = w8; valid_a = 1'b1; sh_a = 1'b0;
        cyc();
        valid_a = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check($sformatf("stall_bit%0d", b), {31'd0, out_a}, {31'd0, w8[7-b]});
            sh_a = 1'b0;
            repeat (2) begin
                cyc();
                check($sformatf("stall_hold%0d", b), {31'd0, out_a}, {31'd0, w8[7-b]});
                check($sformatf("stall_act%0d", b), {31'd0, active_a}, 32'd1);
                check($sformatf("stall_done%0d", b), {31'd0, done_a}, 32'd0);
            end
            sh_a = 1'b1;
            cyc();
        end
        check("stall_done_pulse", {31'd0, done_a}, 32'd1);
        check("stall_idle_act", {31'd0, active_a}, 32'd0);

        // accept on the last-bit edge: 00 then FF, no gap
        din_a = 8'h00; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        for (int b = 0; b < 7; b++) begin
            check($sformatf("last_zero%0d", b), {31'd0, out_a}, 32'd0);
            check($sformatf("last_zact%0d", b), {31'd0, active_a}, 32'd1);
            cyc();
        end
        check("last_zero7", {31'd0, out_a}, 32'd0);
        check("last_ready", {31'd0, ready_a}, 32'd1);
        din_a = 8'hFF; valid_a = 1'b1;
        cyc();
        valid_a = 1'b0;
        check("last_handoff_done", {31'd0, done_a}, 32'd1);
        check("last_handoff_act", {31'd0, active_a}, 32'd1);
        check("last_one0", {31'd0, out_a}, 32'd1);
        check("last_hr_empty", {31'd0, ready_a}, 32'd1);
        for (int b = 1; b < 8; b++) begin
            cyc();
            check($sformatf("last_one%0d", b), {31'd0, out_a}, 32'd1);
            check($sformatf("last_oact%0d", b), {31'd0, active_a}, 32'd1);
        end
        cyc();
        check("last_done_end", {31'd0, done_a}, 32'd1);
        check("last_idle_act", {31'd0, active_a}, 32'd0);

        // reset mid-word with HR full: everything discarded asynchronously
        din_a = 8'hFF; valid_a = 1'b1;
        cyc();
        din_a = 8'hF0;
        cyc();
        valid_a = 1'b0;
        cyc();
        check("mid_act", {31'd0, active_a}, 32'd1);
        check("mid_hr_full", {31'd0, ready_a}, 32'd0);
        #2;
        n_rst = 1'b0;
        #1;
        check_idle_a("async_rst");
        cyc();
        check_idle_a("rst_hold");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) begin
            cyc();
            check_idle_a("post_rst");
        end
        sh_a = 1'b0;

        // LSB-first, 4 bits: 1011 -> 1,1,0,1
        w4 = 4'b1011;
        din_b = w4; valid_b = 1'b1; sh_b = 1'b1;
        cyc();
        valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lsb_bit%0d", i), {31'd0, out_b}, {31'd0, w4[i]});
            check($sformatf("lsb_act%0d", i), {31'd0, active_b}, 32'd1);
            cyc();
        end
        check("lsb_done", {31'd0, done_b}, 32'd1);
        check("lsb_idle_out", {31'd0, out_b}, 32'd0);
        check("lsb_idle_act", {31'd0, active_b}, 32'd0);
        cyc();
        check("lsb_idle_out2", {31'd0, out_b}, 32'd0);
        check("lsb_done_end", {31'd0, done_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
